// File: rtl/uart_tx_buffer.sv
// Byte FIFO with a two-state issue FSM feeding the UART transceiver TX path.
// Each byte gets a one-cycle tx_wr strobe, and the FSM never strobes again until tx_done.
module uart_tx_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  wr_stb,
  input  logic [7:0]            wr_data,
  input  logic                  flush,
  input  logic                  clr_ovf,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  busy,
  output logic                  drained,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  input  logic                  tx_done
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [0:0]            r_state;
  logic                  r_overflow;
  logic                  r_drained;
  logic                  r_tx_wr;
  logic [7:0]            r_tx_data;

  logic w_full;
  logic w_push;
  logic w_issue;
  logic w_ovf_set;

  // Handshakes: wr_stb pushes in the cycle it is high (dropped when full or flushing);
  // tx_wr is a single-cycle start strobe with tx_data valid alongside; tx_done is a
  // single-cycle completion pulse and is only meaningful while a frame is outstanding.
  assign w_full    = (r_level == LVL_FULL);
  assign w_push    = wr_stb & ~w_full & ~flush;
  assign w_ovf_set = wr_stb & w_full & ~flush;
  assign w_issue   = ~flush & (r_level != '0) & ((r_state == S_IDLE) | tx_done);

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_push && !w_issue)      r_level <= r_level + LVL_ONE;
      else if (w_issue && !w_push) r_level <= r_level - LVL_ONE;
    end
  end

  // A fresh overflow in the same cycle as clr_ovf wins.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     r_overflow <= 1'b0;
    else if (w_ovf_set) r_overflow <= 1'b1;
    else if (clr_ovf)   r_overflow <= 1'b0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_tx_wr   <= 1'b0;
      r_tx_data <= 8'h00;
      r_drained <= 1'b0;
    end else begin
      r_tx_wr   <= w_issue;
      r_drained <= 1'b0;
      if (w_issue) r_tx_data <= r_mem[r_rd_ptr];
      case (r_state)
        S_IDLE: if (w_issue) r_state <= S_WAIT;
        S_WAIT: begin
          if (tx_done && !w_issue) begin
            r_state   <= S_IDLE;
            r_drained <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign full     = w_full;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign busy     = (r_state == S_WAIT);
  assign drained  = r_drained;
  assign tx_data  = r_tx_data;
  assign tx_wr    = r_tx_wr;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Testbench for uart_tx_buffer: table vectors, directed corner sequences and a
// randomized stream checked against a queue-based reference model.
module tb_uart_tx_buffer;

  logic       clk;
  logic       rst_n;
  logic       wr_stb;
  logic [7:0] wr_data;
  logic       flush;
  logic       clr_ovf;
  logic       full;
  logic [4:0] level;
  logic       overflow;
  logic       busy;
  logic       drained;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  uart_tx_buffer #(.DEPTH_LOG2(4)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .wr_stb    (wr_stb),
    .wr_data   (wr_data),
    .flush     (flush),
    .clr_ovf   (clr_ovf),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .busy      (busy),
    .drained   (drained),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_done   (tx_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: queued bytes, whether a frame is outstanding, sticky flag
  logic [7:0] m_q[$];
  bit         m_out;
  bit         m_ovf;
  bit         m_drn;
  bit         m_wr;
  logic [7:0] m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_out  = 0;
    m_ovf  = 0;
    m_drn  = 0;
    m_wr   = 0;
    m_data = 8'h00;
  endtask

  task automatic model_step(input bit ws, input logic [7:0] wd, input bit fl,
                            input bit co, input bit td);
    int lvl;
    bit was_full;
    bit iss;
    lvl      = m_q.size();
    was_full = (lvl == 16);
    iss      = !fl && (lvl != 0) && (!m_out || td);
    m_wr     = iss;
    m_drn    = 0;
    if (iss) m_data = m_q[0];
    if (fl) m_q.delete();
    else begin
      if (iss) void'(m_q.pop_front());
      if (ws && !was_full) m_q.push_back(wd);
    end
    if (ws && was_full && !fl) m_ovf = 1;
    else if (co)               m_ovf = 0;
    if (iss) m_out = 1;
    else if (m_out && td) begin
      m_out = 0;
      m_drn = 1;
    end
  endtask

  // driver: one clock cycle, model update, compare after the edge
  task automatic cycle(input bit ws, input logic [7:0] wd, input bit fl,
                       input bit co, input bit td);
    wr_stb  = ws;
    wr_data = wd;
    flush   = fl;
    clr_ovf = co;
    tx_done = td;
    @(posedge clk);
    model_step(ws, wd, fl, co, td);
    #1;
    chk("m_level",    level,    m_q.size());
    chk("m_full",     full,     (m_q.size() == 16));
    chk("m_overflow", overflow, m_ovf);
    chk("m_busy",     busy,     m_out);
    chk("m_drained",  drained,  m_drn);
    chk("m_tx_wr",    tx_wr,    m_wr);
    chk("m_tx_data",  tx_data,  m_data);
    wr_stb  = 0;
    flush   = 0;
    clr_ovf = 0;
    tx_done = 0;
  endtask

  // asynchronous reset, outputs checked before any clock edge
  task automatic reset_dut(input string tag);
    wr_stb  = 0;
    wr_data = 8'h00;
    flush   = 0;
    clr_ovf = 0;
    tx_done = 0;
    rst_n   = 0;
    #2;
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_tx_wr"},    tx_wr,    0);
    chk({tag, "_level"},    level,    0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_full"},     full,     0);
    chk({tag, "_drained"},  drained,  0);
    chk({tag, "_tx_data"},  tx_data,  0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  typedef struct packed {
    logic       ws;
    logic [7:0] wd;
    logic       fl;
    logic       co;
    logic       td;
    logic       e_wr;
    logic [7:0] e_data;
    logic [4:0] e_lvl;
    logic       e_busy;
    logic       e_drn;
  } vec_t;

  vec_t vt[13];

  logic [7:0] exp_q[$];
  logic [7:0] got[$];

  initial begin
    int  wait_cnt;
    bit  pending;
    int  ndone;
    int  nwr;
    int  ndrn;
    int  last_done;
    int  sent;
    int  rcvd;
    int  max_lvl;
    bit  td;
    bit  ws;

    rst_n   = 0;
    wr_stb  = 0;
    wr_data = 0;
    flush   = 0;
    clr_ovf = 0;
    tx_done = 0;
    model_reset();
    #3;
    reset_dut("rst0");

    // table: inputs for one cycle, expected outputs after that edge
    vt[0]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 5'd0, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 5'd1, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 5'd2, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 5'd1, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 5'd1, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 8'hCC, 1'b0, 1'b0, 1'b1, 1'b1, 8'hBB, 5'd1, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hBB, 5'd0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hBB, 5'd0, 1'b0, 1'b1};
    vt[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hBB, 5'd0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hBB, 5'd0, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 8'hBB, 5'd0, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hBB, 5'd0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].ws, vt[i].wd, vt[i].fl, vt[i].co, vt[i].td);
      chk($sformatf("vec%0d_tx_wr", i),   tx_wr,   vt[i].e_wr);
      chk($sformatf("vec%0d_tx_data", i), tx_data, vt[i].e_data);
      chk($sformatf("vec%0d_level", i),   level,   vt[i].e_lvl);
      chk($sformatf("vec%0d_busy", i),    busy,    vt[i].e_busy);
      chk($sformatf("vec%0d_drained", i), drained, vt[i].e_drn);
    end

    // three bytes, tx_done 20 cycles after each tx_wr
    reset_dut("rst2");
    pending = 0; wait_cnt = 0; ndone = 0; nwr = 0; ndrn = 0; last_done = -1;
    got.delete();
    for (int j = 0; j < 100; j++) begin
      td = 0;
      if (pending) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          td = 1;
          pending = 0;
        end
      end
      cycle(j < 3, 8'(j + 1), 1'b0, 1'b0, td);
      if (td) begin
        ndone++;
        last_done = j;
      end
      if (tx_wr) begin
        nwr++;
        got.push_back(tx_data);
        if (nwr > 1) chk("t2_gap", j, last_done);
        pending  = 1;
        wait_cnt = 21;
      end
      if (drained) begin
        ndrn++;
        chk("t2_drn_ndone", ndone, 3);
        chk("t2_drn_at", j, last_done);
      end
    end
    chk("t2_nwr", nwr, 3);
    chk("t2_ndrn", ndrn, 1);
    chk("t2_ngot", got.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) chk($sformatf("t2_byte%0d", k), got[k], k + 1);
    end

    // overflow with tx_done held low
    reset_dut("rst3");
    for (int j = 0; j < 20; j++) begin
      cycle(1'b1, 8'(8'h80 + j), 1'b0, 1'b0, 1'b0);
      if (j == 16) begin
        chk("t3_full_17", full, 1);
        chk("t3_ovf_17", overflow, 0);
      end
      if (j == 17) chk("t3_ovf_18", overflow, 1);
    end
    chk("t3_level", level, 16);
    chk("t3_busy", busy, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("t3_ovf_clr", overflow, 0);
    // overflow and clr_ovf in the same cycle: overflow stays set
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("t3_ovf_coinc", overflow, 1);

    // flush while waiting with five bytes queued
    reset_dut("rst4");
    for (int j = 0; j < 6; j++) cycle(1'b1, 8'(j), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_level5", level, 5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("t4_flushed", level, 0);
    chk("t4_busy", busy, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t4_no_wr", tx_wr, 0);
    chk("t4_drained", drained, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("t4_idle", busy, 0);

    // reset asserted between edges while waiting with overflow set
    for (int j = 0; j < 19; j++) cycle(1'b1, 8'(j), 1'b0, 1'b0, 1'b0);
    chk("t5_pre_busy", busy, 1);
    chk("t5_pre_ovf", overflow, 1);
    reset_dut("t5");

    // randomized stream of 40 incrementing bytes
    exp_q.delete();
    pending = 0; wait_cnt = 0; sent = 0; rcvd = 0; max_lvl = 0;
    for (int j = 0; j < 4000 && !(rcvd == 40 && !m_out); j++) begin
      td = 0;
      if (pending) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          td = 1;
          pending = 0;
        end
      end
      ws = (sent < 40) && (m_q.size() < 16) && ($urandom_range(0, 2) != 0);
      if (ws) exp_q.push_back(8'(sent));
      cycle(ws, 8'(sent), 1'b0, 1'b0, td);
      if (ws) sent++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (tx_wr) begin
        if (exp_q.size() == 0) chk("t6_spurious_wr", 1, 0);
        else chk($sformatf("t6_byte%0d", rcvd), tx_data, exp_q.pop_front());
        rcvd++;
        pending  = 1;
        wait_cnt = $urandom_range(1, 30) + 1;
      end
    end
    chk("t6_rcvd", rcvd, 40);
    chk("t6_max_lvl_ok", (max_lvl <= 16), 1);
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
